// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//   Program-counter / instruction-register stage ahead of the decoder FSM.
//   Holds the PC, drives the unified memory address, latches fetched words,
//   and applies the decoder's next-PC controls. Also tracks a saturating
//   retired-instruction count, a sticky branch-to-self halt flag and a small
//   circular history of taken redirects for debug readout.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   pc_en          : commit next PC this cycle
//   pc_mux_ctrl    : next PC = PC + disp (relative to the branch's own PC)
//   pc_load        : next PC = rtarget (wins over pc_mux_ctrl)
//   disp, rtarget  : sign-extended displacement, register jump target
//   ir_en          : capture mem_dout into ir_reg
//   LS_ctrl, raddr : 1 selects raddr as memory address, 0 selects PC
//   mem_dout       : memory read data
//   hist_idx       : redirect history index, 0 = most recent
//   pc, mem_addr   : current PC (zero-extended), combinational memory address
//   ir_reg         : instruction register
//   retired        : committed PC updates, saturating at 16'hFFFF
//   halted         : sticky, a commit targeted its own PC
//   hist_pc        : source PC of the selected redirect, 0 if not valid
//   hist_count     : valid history entries, saturating at HIST_DEPTH
module pc_fetch_unit #(
  parameter int          ADDR_BITS  = 16,
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          HIST_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pc_en,
  input  logic                          pc_mux_ctrl,
  input  logic                          pc_load,
  input  logic [15:0]                   disp,
  input  logic [15:0]                   rtarget,
  input  logic                          ir_en,
  input  logic                          LS_ctrl,
  input  logic [15:0]                   raddr,
  input  logic [15:0]                   mem_dout,
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
  output logic [15:0]                   pc,
  output logic [15:0]                   mem_addr,
  output logic [15:0]                   ir_reg,
  output logic [15:0]                   retired,
  output logic                          halted,
  output logic [15:0]                   hist_pc,
  output logic [4:0]                    hist_count
);

  localparam int IDX_W = $clog2(HIST_DEPTH);

  logic [ADDR_BITS-1:0] pc_q;
  logic [ADDR_BITS-1:0] next_pc;
  logic [ADDR_BITS-1:0] hist_mem [HIST_DEPTH];
  logic [IDX_W-1:0]     wptr_q;
  logic [IDX_W-1:0]     rd_ptr;
  logic [4:0]           hist_count_q;
  logic [15:0]          ir_q;
  logic [15:0]          retired_q;
  logic                 halted_q;
  logic                 redirect;

  // Next-PC select. Arithmetic is done at ADDR_BITS width so wrap-around
  // modulo 2^ADDR_BITS falls out of the truncation.
  always_comb begin
    next_pc = pc_q + ADDR_BITS'(1);
    if (pc_load) begin
      next_pc = rtarget[ADDR_BITS-1:0];
    end else if (pc_mux_ctrl) begin
      next_pc = pc_q + disp[ADDR_BITS-1:0];
    end
  end

  assign redirect = pc_en && (pc_load || pc_mux_ctrl);

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q         <= RESET_PC[ADDR_BITS-1:0];
      ir_q         <= '0;
      retired_q    <= '0;
      halted_q     <= 1'b0;
      wptr_q       <= '0;
      hist_count_q <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_mem[i] <= '0;
      end
    end else begin
      if (ir_en) begin
        ir_q <= mem_dout;
      end
      if (pc_en) begin
        pc_q <= next_pc;
        if (retired_q != 16'hFFFF) begin
          retired_q <= retired_q + 16'd1;
        end
        if (next_pc == pc_q) begin
          halted_q <= 1'b1;
        end
      end
      if (redirect) begin
        hist_mem[wptr_q] <= pc_q;
        // HIST_DEPTH is a power of two, so the pointer wraps naturally.
        wptr_q <= wptr_q + IDX_W'(1);
        if (hist_count_q != 5'(HIST_DEPTH)) begin
          hist_count_q <= hist_count_q + 5'd1;
        end
      end
    end
  end

  // Most recent entry sits just behind the write pointer.
  assign rd_ptr = wptr_q - IDX_W'(1) - hist_idx;

  always_comb begin
    pc                 = '0;
    pc[ADDR_BITS-1:0]  = pc_q;
    hist_pc            = '0;
    if (5'(hist_idx) < hist_count_q) begin
      hist_pc[ADDR_BITS-1:0] = hist_mem[rd_ptr];
    end
  end

  assign mem_addr   = LS_ctrl ? raddr : pc;
  assign ir_reg     = ir_q;
  assign retired    = retired_q;
  assign halted     = halted_q;
  assign hist_count = hist_count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (ADDR_BITS 16 and 8) share all
// inputs; a behavioural model tracks each one, with the redirect history
// kept as a most-recent-first shift list.
module tb_pc_fetch_unit;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pc_en, pc_mux_ctrl, pc_load, ir_en, LS_ctrl;
  logic [15:0] disp, rtarget, raddr, mem_dout;
  logic [1:0]  hist_idx;

  logic [15:0] pc_o [2];
  logic [15:0] mem_addr_o [2];
  logic [15:0] ir_o [2];
  logic [15:0] ret_o [2];
  logic        halted_o [2];
  logic [15:0] hpc_o [2];
  logic [4:0]  hcnt_o [2];

  pc_fetch_unit u_dut16 (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_mux_ctrl(pc_mux_ctrl),
    .pc_load(pc_load), .disp(disp), .rtarget(rtarget), .ir_en(ir_en),
    .LS_ctrl(LS_ctrl), .raddr(raddr), .mem_dout(mem_dout), .hist_idx(hist_idx),
    .pc(pc_o[0]), .mem_addr(mem_addr_o[0]), .ir_reg(ir_o[0]),
    .retired(ret_o[0]), .halted(halted_o[0]), .hist_pc(hpc_o[0]),
    .hist_count(hcnt_o[0])
  );

  pc_fetch_unit #(.ADDR_BITS(8)) u_dut8 (
    .clk(clk), .reset(reset), .pc_en(pc_en), .pc_mux_ctrl(pc_mux_ctrl),
    .pc_load(pc_load), .disp(disp), .rtarget(rtarget), .ir_en(ir_en),
    .LS_ctrl(LS_ctrl), .raddr(raddr), .mem_dout(mem_dout), .hist_idx(hist_idx),
    .pc(pc_o[1]), .mem_addr(mem_addr_o[1]), .ir_reg(ir_o[1]),
    .retired(ret_o[1]), .halted(halted_o[1]), .hist_pc(hpc_o[1]),
    .hist_count(hcnt_o[1])
  );

  // ---------------- scoreboard / checker ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [15:0] obs,
                          input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [15:0] m_pc [2];
  logic        m_halt [2];
  logic [15:0] m_hist [2][4];   // index 0 = most recent redirect source
  int          m_cnt [2];
  logic [15:0] m_ir, m_ret;

  function automatic logic [15:0] mask_of(input int k);
    return (k == 0) ? 16'hFFFF : 16'h00FF;
  endfunction

  task automatic model_step();
    logic [15:0] nxt;
    if (reset) begin
      m_ir  = '0;
      m_ret = '0;
      for (int k = 0; k < 2; k++) begin
        m_pc[k] = '0; m_halt[k] = 1'b0; m_cnt[k] = 0;
        for (int i = 0; i < 4; i++) m_hist[k][i] = '0;
      end
    end else begin
      if (ir_en) m_ir = mem_dout;
      if (pc_en) begin
        for (int k = 0; k < 2; k++) begin
          if (pc_load)          nxt = rtarget & mask_of(k);
          else if (pc_mux_ctrl) nxt = (m_pc[k] + disp) & mask_of(k);
          else                  nxt = (m_pc[k] + 16'd1) & mask_of(k);
          if (nxt == m_pc[k]) m_halt[k] = 1'b1;
          if (pc_load || pc_mux_ctrl) begin
            for (int i = 3; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
            m_hist[k][0] = m_pc[k];
            if (m_cnt[k] < 4) m_cnt[k]++;
          end
          m_pc[k] = nxt;
        end
        if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
      end
    end
  endtask

  task automatic compare_all();
    logic [15:0] exp_h;
    for (int k = 0; k < 2; k++) begin
      exp_h = (int'(hist_idx) < m_cnt[k]) ? m_hist[k][hist_idx] : 16'h0000;
      check_eq($sformatf("pc[%0d]", k), pc_o[k], m_pc[k]);
      check_eq($sformatf("mem_addr[%0d]", k), mem_addr_o[k],
               LS_ctrl ? raddr : m_pc[k]);
      check_eq($sformatf("ir_reg[%0d]", k), ir_o[k], m_ir);
      check_eq($sformatf("retired[%0d]", k), ret_o[k], m_ret);
      check_eq($sformatf("halted[%0d]", k), 16'(halted_o[k]), 16'(m_halt[k]));
      check_eq($sformatf("hist_pc[%0d]", k), hpc_o[k], exp_h);
      check_eq($sformatf("hist_count[%0d]", k), 16'(hcnt_o[k]), 16'(m_cnt[k]));
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic drive(input logic en, input logic ld, input logic mx,
                       input logic [15:0] tgt, input logic [15:0] d);
    pc_en = en; pc_load = ld; pc_mux_ctrl = mx; rtarget = tgt; disp = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; ir_en = 1'b0; LS_ctrl = 1'b0; raddr = '0; mem_dout = '0;
    hist_idx = '0;
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    do_reset();
    check_eq("rst_pc", pc_o[0], 16'h0000);
    check_eq("rst_hist_count", 16'(hcnt_o[0]), 16'h0000);

    // Plain increments
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    check_eq("incr_pc", pc_o[0], 16'h0003);
    check_eq("incr_retired", ret_o[0], 16'h0003);

    // Relative backward branch from PC=5
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (5) tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'hFFFD);
    tick();
    check_eq("branch_pc", pc_o[0], 16'h0002);
    check_eq("branch_hist_count", 16'(hcnt_o[0]), 16'h0001);
    check_eq("branch_hist_pc", hpc_o[0], 16'h0005);

    // Load wins over relative, then held while paused
    drive(1'b1, 1'b1, 1'b1, 16'h0040, 16'h0004);
    tick();
    check_eq("load_prio_pc", pc_o[0], 16'h0040);
    drive(1'b0, 1'b1, 1'b0, 16'h0099, 16'h0004);
    repeat (2) tick();
    check_eq("load_paused_pc", pc_o[0], 16'h0040);

    // Wrap of the 8-bit instance, then branch-to-self halt
    drive(1'b1, 1'b1, 1'b0, 16'h00FF, 16'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    check_eq("wrap8_pc", pc_o[1], 16'h0000);
    check_eq("nowrap16_pc", pc_o[0], 16'h0100);
    drive(1'b1, 1'b1, 1'b0, 16'd10, 16'h0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 16'h0, 16'h0000);
    tick();
    check_eq("halt_flag", 16'(halted_o[1]), 16'h0001);
    check_eq("halt_pc", pc_o[1], 16'd10);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    repeat (3) tick();
    check_eq("halt_sticky", 16'(halted_o[0]), 16'h0001);

    // Six redirects from PCs 1..6
    do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
    tick();
    for (int p = 1; p <= 6; p++) begin
      drive(1'b1, 1'b1, 1'b0, 16'(p + 1), 16'h0);
      tick();
    end
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
    check_eq("hist6_count", 16'(hcnt_o[0]), 16'h0004);
    for (int i = 0; i < 4; i++) begin
      hist_idx = 2'(i);
      #1;
      check_eq($sformatf("hist6_idx%0d", i), hpc_o[0], 16'(6 - i));
    end

    // Load/store address is combinational
    LS_ctrl = 1'b1; raddr = 16'h1234;
    #1;
    check_eq("ls_mem_addr", mem_addr_o[0], 16'h1234);

    // Instruction capture
    ir_en = 1'b1; mem_dout = 16'hC1FE;
    tick();
    ir_en = 1'b0; mem_dout = 16'h0000;
    check_eq("ir_capture", ir_o[0], 16'hC1FE);

    // Reset with a jump pending discards it
    LS_ctrl = 1'b0;
    drive(1'b1, 1'b1, 1'b0, 16'h0777, 16'h0);
    do_reset();
    check_eq("rst_mid_pc", pc_o[0], 16'h0000);
    check_eq("rst_mid_hist", 16'(hcnt_o[0]), 16'h0000);
    check_eq("rst_mid_ir", ir_o[0], 16'h0000);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      pc_en       = ($urandom_range(0, 3) != 0);
      pc_load     = ($urandom_range(0, 4) == 0);
      pc_mux_ctrl = ($urandom_range(0, 3) == 0);
      rtarget     = ($urandom_range(0, 3) == 0) ? pc_o[$urandom_range(0, 1)]
                                                : 16'($urandom);
      case ($urandom_range(0, 3))
        0:       disp = 16'h0000;
        1:       disp = 16'($signed(6'($urandom)));
        default: disp = 16'($urandom);
      endcase
      ir_en    = $urandom_range(0, 1) == 1;
      mem_dout = 16'($urandom);
      LS_ctrl  = $urandom_range(0, 1) == 1;
      raddr    = 16'($urandom);
      hist_idx = 2'($urandom_range(0, 3));
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_unit.md
# pc_fetch_unit

Program-counter and instruction-register stage that sits directly upstream of the control/decoder FSM. It holds the PC and drives the unified memory address (PC or load/store address). It latches fetched words into the instruction register and applies the decoder's `pc_en` / `pc_mux_ctrl` / `pc_load` / `disp` controls to compute the next PC. It also keeps a retired-instruction count, a sticky branch-to-self halt flag, and a small circular history of taken redirects for debug readout.

## Interface
- `ADDR_BITS`, default 16: PC width; PC arithmetic wraps modulo 2^ADDR_BITS (legal range 4..16).
- `RESET_PC`, default 16'h0000: PC value after reset (low ADDR_BITS used).
- `HIST_DEPTH`, default 4: redirect-history entries; power of two, 2..16.

- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc_en`  in  1  commit next PC this cycle.
- `pc_mux_ctrl`  in  1  next PC = PC + disp (relative branch).
- `pc_load`  in  1  next PC = `rtarget` (register jump).
- `disp`  in  16  signed displacement, already sign-extended by decoder.
- `rtarget`  in  16  jump target from register file.
- `ir_en`  in  1  capture `mem_dout` into `ir_reg`.
- `LS_ctrl`  in  1  1: memory address = `raddr`; 0: memory address = PC.
- `raddr`  in  16  load/store address from register file.
- `mem_dout`  in  16  memory read data.
- `hist_idx`  in  log2(HIST_DEPTH)  history readout index, 0 = most recent.
- `pc`  out  16  current PC, zero-extended above ADDR_BITS.
- `mem_addr`  out  16  memory address, combinational.
- `ir_reg`  out  16  instruction register.
- `retired`  out  16  count of committed PC updates.
- `halted`  out  1  sticky: a commit targeted its own PC.
- `hist_pc`  out  16  source PC of the selected redirect entry.
- `hist_count`  out  5  number of valid history entries, saturates at HIST_DEPTH.

## Operation
- Next-PC select is applied only when `pc_en`=1. Priority: `pc_load` > `pc_mux_ctrl` > increment.
  - load: `rtarget[ADDR_BITS-1:0]`.
  - relative: (PC + `disp`) mod 2^ADDR_BITS. `disp` is two's complement. Target is relative to the PC of the branch itself, because the PC is not yet incremented when the decoder executes.
  - increment: (PC + 1) mod 2^ADDR_BITS.
- `pc_en`=0: PC holds regardless of `pc_load` / `pc_mux_ctrl`. The decoder may hold `pc_load` high while paused.
- `mem_addr` = `LS_ctrl` ? `raddr` : `pc`. Purely combinational, no added latency.
- `ir_reg` <= `mem_dout` on edges where `ir_en`=1; otherwise holds.
- `retired` increments by 1 on every `pc_en` edge and saturates at 16'hFFFF.
- `halted` sets on a `pc_en` edge whose selected next PC equals the current PC. It clears only on reset. PC continues to obey controls while `halted`=1.
- Redirect history:
  - On a `pc_en` edge with `pc_load` or `pc_mux_ctrl` set, write the current PC into a circular buffer at the write pointer.
  - The write pointer advances modulo HIST_DEPTH; on wrap, the oldest entry is overwritten.
  - `hist_count` increments and saturates.
  - `hist_pc` = entry (wptr-1-`hist_idx`) mod HIST_DEPTH, combinational.
  - If `hist_idx` >= `hist_count`, `hist_pc` = 0.

## Timing
- Reset (`reset`=1 at an edge) overrides all other inputs in that cycle. Values after reset: `pc`=RESET_PC, `ir_reg`=0, `retired`=0, `halted`=0, `hist_count`=0, write pointer=0, all history entries=0.
- Resulting outputs: `hist_pc`=0, and `mem_addr` = RESET_PC (or `raddr` if `LS_ctrl`=1).
- Reset asserted mid-sequence, e.g. while a jump is pending, discards the redirect. The history is not written.
- PC update latency: one edge. New `pc` and `mem_addr` are visible in the cycle after `pc_en`.
- IR latency: one edge after `ir_en`. `ir_reg` is stable for all following decoder states until the next `ir_en`.
- `ir_en` and `pc_en` in the same cycle: both take effect independently. `ir_reg` captures data addressed by the old `mem_addr`.
- At `retired`=FFFF, a further `pc_en` leaves it at FFFF.
- A `pc_en` with `pc_load` and `pc_mux_ctrl` both set records one history entry, and the load target is used.

## Test plan
- Reset, then `pc_en`=1 for 3 cycles with no redirect. Expect: `pc` 0→1→2→3, `retired`=3, `halted`=0, `hist_count`=0.
- PC=5, `pc_mux_ctrl`=1, `disp`=16'hFFFD, `pc_en`=1. Expect: `pc`=2, `hist_count`=1, `hist_pc`(idx 0)=5.
- PC=2, `pc_load`=1 and `pc_mux_ctrl`=1, `rtarget`=16'h0040, `disp`=4. Expect: `pc`=16'h0040.
  - Then `pc_load`=1 with `pc_en`=0. Expect: PC stays 16'h0040.
- ADDR_BITS=8, PC=8'hFF, increment. Expect: `pc`=0.
  - Then PC=10, `pc_mux_ctrl`=1, `disp`=0, `pc_en`=1. Expect: `halted`=1, `pc`=10, and `halted` remains 1 after later normal increments until `reset`.
- Six taken redirects from PCs 1..6 with HIST_DEPTH=4. Expect: `hist_count`=4, idx0..3 = 6,5,4,3.
  - Then `LS_ctrl`=1, `raddr`=16'h1234. Expect: `mem_addr`=16'h1234 the same cycle.
  - Then `ir_en`=1 with `mem_dout`=16'hC1FE. Expect: `ir_reg`=16'hC1FE on the next cycle.
  - Then `reset` mid-sequence. Expect: all outputs return to reset values.
